macguffin_decrypt: RTL and testbench
====================================

# macguffin_decrypt

Iterative MacGuffin block decryptor, the inverse of the team's MacGuffin encoder. It takes 64-bit ciphertext blocks on an AXI-Stream slave and returns 64-bit plaintext blocks on an AXI-Stream master. It uses the same 48-bit key and the same round-key schedule as the encoder, applied in reverse order. It sits between the 8→64 and 64→8 axis_fifo_adapter instances in the decrypt-side top, in the same position the encoder occupies on the encrypt side.

## Interface
Parameters:
- ROUNDS, 32: number of Feistel rounds. Must equal the encoder's value.
- ROUNDS_PER_CYCLE, 1: rounds unrolled per clock. Legal values are 1, 2 and 4; each must divide ROUNDS.

Ports:
- clk  in  1  single clock.
- rst  in  1  asynchronous, active-high reset.
- key  in  48  cipher key. Sampled only on input handshake.
- s_axis_tdata  in  64  ciphertext. Word w_j = tdata[16j+15:16j].
- s_axis_tvalid  in  1  ciphertext valid.
- s_axis_tready  out  1  high only in IDLE.
- m_axis_tdata  out  64  plaintext, same word packing as input.
- m_axis_tvalid  out  1  plaintext valid.
- m_axis_tready  in  1  downstream ready.

## Operation
- FSM states: IDLE, RUN, DONE. Reset state is IDLE.
- **IDLE**
  - s_axis_tready = 1.
  - On s_axis_tvalid & s_axis_tready: latch tdata into state words r0..r3, latch key into key_q, set rnd = ROUNDS-1, go to RUN.
- **RUN**: each cycle applies ROUNDS_PER_CYCLE inverse rounds. For the current rnd, one inverse round is:
  - un-rotate: (r0,r1,r2,r3) ← (r3,r0,r1,r2);
  - r0 ← r0 ^ F(r1^ka, r2^kb, r3^kc), where {kc,kb,ka} = round_key(key_q, rnd);
  - rnd ← rnd-1.
  - After the round with rnd = 0, go to DONE.
- **F**: the eight MacGuffin 6→2 S-boxes, using the shared input-bit selection and output placement. Output is 16 bits. F is identical to the encoder's F.
- **round_key(k, i)**: rotl48(k, 3·i mod 48), returned as 48 bits. The encoder uses the same function.
- **DONE**
  - m_axis_tvalid = 1, m_axis_tdata = {r3,r2,r1,r0}.
  - Data is held stable until m_axis_tready.
  - On handshake, go to IDLE.
- key changes after the input handshake have no effect on a block in flight.
- s_axis_tvalid while the FSM is not in IDLE is ignored; tready is 0, so no data is lost.
- rnd is a $clog2(ROUNDS)-bit down-counter. It never wraps, because the exit condition is tested before decrement.
- Reset asserted mid-operation: the block in flight is discarded and nothing is emitted. All outputs take their reset values asynchronously.

## Timing
- Reset values:
  - s_axis_tready = 0, m_axis_tvalid = 0, m_axis_tdata = 0.
  - s_axis_tready rises on the first clock edge after rst deasserts.
- All outputs are registered or decoded from the state register. There is no combinational path from input to output.
- Input handshake at edge T:
  - RUN occupies ROUNDS/ROUNDS_PER_CYCLE cycles.
  - m_axis_tvalid is high from edge T + ROUNDS/ROUNDS_PER_CYCLE, which is 32 cycles for the defaults.
- Output handshake at edge U puts the FSM in IDLE, with s_axis_tready = 1 in the cycle after U.
- Minimum block period: ROUNDS/ROUNDS_PER_CYCLE + 2 cycles (34 for the defaults).
- Holding m_axis_tready = 1 constantly still yields the minimum period. Holding it low stalls the FSM in DONE indefinitely.

## Structure
- Shared package macguffin_pkg, also used by the encoder, holds:
  - S-box tables;
  - S-box bit-selection constants;
  - function f_mix(16,16,16)→16;
  - function round_key(48-bit key, round index);
  - localparam BLOCK_W = 64, KEY_W = 48, WORD_W = 16;
  - the state enum typedef.
- One natural sub-module: macguffin_round_inv. It is combinational, maps one inverse round from (r0..r3, subkey) to (r0..r3), and is instantiated ROUNDS_PER_CYCLE times in a chain.

## Test plan
- **Round trip:** encoder with key = 48'h0 on P = 64'h0123_4567_89AB_CDEF gives C; decryptor with key = 48'h0 on C gives P. Repeat with key = 48'hA5A5_5A5A_F00F.
- **Latency and period:** single block with m_axis_tready held at 1 → m_axis_tvalid exactly 32 cycles after the input handshake. Two back-to-back blocks → input handshakes 34 cycles apart.
- **Backpressure:** m_axis_tready low for 10 cycles while in DONE → tdata and tvalid stay constant, s_axis_tready stays 0. Releasing m_axis_tready gives one transfer and no duplicate.
- **Key change in flight:** change key 5 cycles after the input handshake → output still equals the plaintext under the original key.
- **Mid-run reset:** assert rst at round 10 of a block → outputs go to 0 immediately. After release, no stale output appears, and the next block decrypts correctly.
- **Unroll parameter:** ROUNDS_PER_CYCLE = 4 with 1000 random round trips → all match, latency is 8 cycles, period is 10 cycles.

Source files
------------

// File: rtl/macguffin_pkg.sv
`default_nettype none
// ============================================================================
// Module   : macguffin_pkg
// Brief    : MacGuffin S-boxes, F mixing function and round-key schedule,
//            shared by the encoder and the decoder.
// Revision : 1.0
// ============================================================================
package macguffin_pkg;

    localparam int BLOCK_W = 64;
    localparam int KEY_W   = 48;
    localparam int WORD_W  = 16;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    // Per S-box: two bit positions of a, two of b, two of c; the first listed
    // position becomes bit 0 of the 6-bit S-box index.
    localparam logic [0:7][0:5][3:0] SBOX_SEL = {
        24'h2569BD, 24'h147A8E, 24'h368D0F, 24'hCE124A,
        24'h0A3E6C, 24'h78CF15, 24'h9F5B27, 24'hBD0439
    };

    // 64 two-bit entries per S-box; entry n occupies bits [2n+1:2n].
    localparam logic [0:7][127:0] SBOX_TBL = {
        128'hE4D12FB8_3A6C590E_0F74E2D1_A6CB9538,
        128'hF18E6B34_972DC05A_3D47F28E_C01A69B5,
        128'hA09E63F5_1DC7B428_D709346A_285ECBF1,
        128'h7DE3069A_1285BC4F_D8B56F03_472CE1A9,
        128'h2C417AB6_853FD0E9_EB2C47D1_50FA6398,
        128'hC1AF9268_0D34E75B_AF427C95_61DE0B38,
        128'h4B2EF08D_3C975A61_D0B7491A_E3586CF2,
        128'hD2846FB1_A93E50C7_1FD8A374_C56B0E92
    };

    function automatic logic [WORD_W-1:0] f_mix(
        input logic [WORD_W-1:0] a,
        input logic [WORD_W-1:0] b,
        input logic [WORD_W-1:0] c
    );
        logic [WORD_W-1:0] y;
        logic [0:5][3:0]   sel;
        logic [5:0]        idx;
        logic [1:0]        o;
        y = '0;
        for (int s = 0; s < 8; s++) begin
            sel = SBOX_SEL[3'(s)];
            idx = {c[sel[5]], c[sel[4]], b[sel[3]], b[sel[2]], a[sel[1]], a[sel[0]]};
            o   = SBOX_TBL[3'(s)][{idx, 1'b0} +: 2];
            y   = y | (WORD_W'(o) << (2 * s));
        end
        return y;
    endfunction

    // Round i uses the key rotated left by 3*i bits (mod 48).
    function automatic logic [KEY_W-1:0] round_key(
        input logic [KEY_W-1:0] k,
        input logic [7:0]       rnd
    );
        logic [5:0] sh;
        sh = 6'((10'(rnd) * 10'd3) % 10'd48);
        return (k << sh) | (k >> (6'd48 - sh));
    endfunction

endpackage
`default_nettype wire

// File: rtl/macguffin_round_inv.sv
`default_nettype none
// ============================================================================
// Module   : macguffin_round_inv
// Brief    : One combinational MacGuffin inverse round.
// Revision : 1.0
// ============================================================================
module macguffin_round_inv
    import macguffin_pkg::*;
(
    input  logic [BLOCK_W-1:0] blk_i,
    input  logic [KEY_W-1:0]   subkey_i,
    output logic [BLOCK_W-1:0] blk_o
);

    logic [WORD_W-1:0] w_r0;
    logic [WORD_W-1:0] w_r1;
    logic [WORD_W-1:0] w_r2;
    logic [WORD_W-1:0] w_r3;
    logic [WORD_W-1:0] w_f;

    // Undo the encoder's word rotation, then strip F back off the target word.
    assign w_r0 = blk_i[3*WORD_W +: WORD_W];
    assign w_r1 = blk_i[0*WORD_W +: WORD_W];
    assign w_r2 = blk_i[1*WORD_W +: WORD_W];
    assign w_r3 = blk_i[2*WORD_W +: WORD_W];

    assign w_f = f_mix(w_r1 ^ subkey_i[0*WORD_W +: WORD_W],
                       w_r2 ^ subkey_i[1*WORD_W +: WORD_W],
                       w_r3 ^ subkey_i[2*WORD_W +: WORD_W]);

    assign blk_o = {w_r3, w_r2, w_r1, w_r0 ^ w_f};

endmodule
`default_nettype wire

// File: rtl/macguffin_decrypt.sv
`default_nettype none
// ============================================================================
// Module   : macguffin_decrypt
// Brief    : Iterative MacGuffin block decryptor with AXI-Stream in/out.
// Revision : 1.0
// ============================================================================
module macguffin_decrypt
    import macguffin_pkg::*;
#(
    parameter int ROUNDS           = 32,
    parameter int ROUNDS_PER_CYCLE = 1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [KEY_W-1:0]   key,
    input  logic [BLOCK_W-1:0] s_axis_tdata,
    input  logic               s_axis_tvalid,
    output logic               s_axis_tready,
    output logic [BLOCK_W-1:0] m_axis_tdata,
    output logic               m_axis_tvalid,
    input  logic               m_axis_tready
);

    localparam int RND_W = $clog2(ROUNDS);

    state_e             state_q, state_d;
    logic [BLOCK_W-1:0] blk_q, blk_d;
    logic [KEY_W-1:0]   key_q, key_d;
    logic [RND_W-1:0]   rnd_q, rnd_d;
    logic               tready_q, tready_d;

    logic [BLOCK_W-1:0] w_chain [ROUNDS_PER_CYCLE+1];

    assign w_chain[0] = blk_q;

    // Stage g of the chain handles round rnd_q - g.
    for (genvar g = 0; g < ROUNDS_PER_CYCLE; g++) begin : g_round
        logic [RND_W-1:0] w_idx;
        logic [KEY_W-1:0] w_subkey;

        assign w_idx    = rnd_q - RND_W'(g);
        assign w_subkey = round_key(key_q, 8'(w_idx));

        macguffin_round_inv u_round (
            .blk_i    (w_chain[g]),
            .subkey_i (w_subkey),
            .blk_o    (w_chain[g+1])
        );
    end

    always_comb begin
        state_d = state_q;
        blk_d   = blk_q;
        key_d   = key_q;
        rnd_d   = rnd_q;
        unique case (state_q)
            ST_IDLE: begin
                if (s_axis_tvalid && tready_q) begin
                    blk_d   = s_axis_tdata;
                    key_d   = key;
                    rnd_d   = RND_W'(ROUNDS - 1);
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                blk_d = w_chain[ROUNDS_PER_CYCLE];
                // Exit is tested before the decrement so rnd never wraps.
                if (rnd_q == RND_W'(ROUNDS_PER_CYCLE - 1)) begin
                    state_d = ST_DONE;
                end else begin
                    rnd_d = rnd_q - RND_W'(ROUNDS_PER_CYCLE);
                end
            end
            ST_DONE: begin
                if (m_axis_tready) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
        tready_d = (state_d == ST_IDLE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            blk_q    <= '0;
            key_q    <= '0;
            rnd_q    <= '0;
            tready_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            blk_q    <= blk_d;
            key_q    <= key_d;
            rnd_q    <= rnd_d;
            tready_q <= tready_d;
        end
    end

    assign s_axis_tready = tready_q;
    assign m_axis_tvalid = (state_q == ST_DONE);
    assign m_axis_tdata  = blk_q;

endmodule
`default_nettype wire

// File: tb/tb_macguffin_decrypt.sv
`default_nettype none
// ============================================================================
// Module   : tb_macguffin_decrypt
// Brief    : Scoreboard bench: ciphertext from a forward-cipher model, the
//            known plaintext queued as the expected decryptor output.
// Revision : 1.0
// ============================================================================
module tb_macguffin_decrypt;

    localparam int TB_ROUNDS = 32;

    localparam int TB_SEL [8][6] = '{
        '{2, 5, 6, 9, 11, 13}, '{1, 4, 7, 10, 8, 14},
        '{3, 6, 8, 13, 0, 15}, '{12, 14, 1, 2, 4, 10},
        '{0, 10, 3, 14, 6, 12}, '{7, 8, 12, 15, 1, 5},
        '{9, 15, 5, 11, 2, 7}, '{11, 13, 0, 4, 3, 9}
    };

    localparam logic [127:0] TB_SBOX [8] = '{
        128'hE4D12FB8_3A6C590E_0F74E2D1_A6CB9538,
        128'hF18E6B34_972DC05A_3D47F28E_C01A69B5,
        128'hA09E63F5_1DC7B428_D709346A_285ECBF1,
        128'h7DE3069A_1285BC4F_D8B56F03_472CE1A9,
        128'h2C417AB6_853FD0E9_EB2C47D1_50FA6398,
        128'hC1AF9268_0D34E75B_AF427C95_61DE0B38,
        128'h4B2EF08D_3C975A61_D0B7491A_E3586CF2,
        128'hD2846FB1_A93E50C7_1FD8A374_C56B0E92
    };

    logic        clk;
    logic        rst1, rst4;
    logic [47:0] key1, key4;
    logic [63:0] sd1, sd4, md1, md4;
    logic        sv1, sr1, mv1, mr1;
    logic        sv4, sr4, mv4, mr4;

    int          cyc;
    int          n_checks;
    int          n_errors;
    logic [63:0] exp1 [$];
    logic [63:0] exp4 [$];

    macguffin_decrypt #(.ROUNDS(32), .ROUNDS_PER_CYCLE(1)) dut1 (
        .clk(clk), .rst(rst1), .key(key1),
        .s_axis_tdata(sd1), .s_axis_tvalid(sv1), .s_axis_tready(sr1),
        .m_axis_tdata(md1), .m_axis_tvalid(mv1), .m_axis_tready(mr1)
    );

    macguffin_decrypt #(.ROUNDS(32), .ROUNDS_PER_CYCLE(4)) dut4 (
        .clk(clk), .rst(rst4), .key(key4),
        .s_axis_tdata(sd4), .s_axis_tvalid(sv4), .s_axis_tready(sr4),
        .m_axis_tdata(md4), .m_axis_tvalid(mv4), .m_axis_tready(mr4)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- forward-cipher reference ----------------
    function automatic logic [15:0] tb_f(input logic [15:0] a, input logic [15:0] b,
                                         input logic [15:0] c);
        logic [15:0]  y;
        logic [127:0] t;
        int           idx;
        y = '0;
        for (int s = 0; s < 8; s++) begin
            idx = int'(a[TB_SEL[s][0]]) + 2 * int'(a[TB_SEL[s][1]])
                + 4 * int'(b[TB_SEL[s][2]]) + 8 * int'(b[TB_SEL[s][3]])
                + 16 * int'(c[TB_SEL[s][4]]) + 32 * int'(c[TB_SEL[s][5]]);
            t = TB_SBOX[s];
            y[2*s]   = t[2*idx];
            y[2*s+1] = t[2*idx+1];
        end
        return y;
    endfunction

    function automatic logic [47:0] tb_rotl48(input logic [47:0] k, input int sh);
        logic [95:0] d;
        d = {k, k} << sh;
        return d[95:48];
    endfunction

    function automatic logic [63:0] enc(input logic [63:0] p, input logic [47:0] k);
        logic [15:0] r [4];
        logic [15:0] t0;
        logic [47:0] rk;
        for (int j = 0; j < 4; j++) r[j] = p[16*j +: 16];
        for (int i = 0; i < TB_ROUNDS; i++) begin
            rk   = tb_rotl48(k, (3 * i) % 48);
            t0   = r[0] ^ tb_f(r[1] ^ rk[15:0], r[2] ^ rk[31:16], r[3] ^ rk[47:32]);
            r[0] = r[1];
            r[1] = r[2];
            r[2] = r[3];
            r[3] = t0;
        end
        return {r[3], r[2], r[1], r[0]};
    endfunction

    // ---------------- comparison helpers ----------------
    task automatic check64(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%h, expected 0x%h", name, act, exp);
        end
    endtask

    task automatic check_bit(input string name, input logic act, input logic exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %b, expected %b", name, act, exp);
        end
    endtask

    task automatic check_int(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic bound_fail(input string name);
        n_checks++;
        n_errors++;
        $display("FAIL %s: wait bound expired", name);
    endtask

    // ---------------- monitors ----------------
    always @(negedge clk) begin
        if (mv1 && mr1) begin
            if (exp1.size() == 0) begin
                n_checks++;
                n_errors++;
                $display("FAIL dut1 unexpected output: got 0x%h, expected none", md1);
            end else begin
                check64("dut1 plaintext", md1, exp1.pop_front());
            end
        end
    end

    always @(negedge clk) begin
        if (mv4 && mr4) begin
            if (exp4.size() == 0) begin
                n_checks++;
                n_errors++;
                $display("FAIL dut4 unexpected output: got 0x%h, expected none", md4);
            end else begin
                check64("dut4 plaintext", md4, exp4.pop_front());
            end
        end
    end

    // ---------------- drivers ----------------
    task automatic send1(input logic [63:0] p, input logic [47:0] k, input bit push, output int hs);
        int n;
        sd1 = enc(p, k);
        key1 = k;
        sv1 = 1'b1;
        hs = -1;
        n = 0;
        while (hs < 0 && n < 200) begin
            @(negedge clk);
            if (sr1) hs = cyc + 1;
            @(posedge clk); #1;
            n++;
        end
        sv1 = 1'b0;
        if (hs < 0) bound_fail("dut1 input handshake");
        else if (push) exp1.push_back(p);
    endtask

    task automatic send4(input logic [63:0] p, input logic [47:0] k, output int hs);
        int n;
        sd4 = enc(p, k);
        key4 = k;
        sv4 = 1'b1;
        hs = -1;
        n = 0;
        while (hs < 0 && n < 200) begin
            @(negedge clk);
            if (sr4) hs = cyc + 1;
            @(posedge clk); #1;
            n++;
        end
        sv4 = 1'b0;
        if (hs < 0) bound_fail("dut4 input handshake");
        else exp4.push_back(p);
    endtask

    task automatic wait_valid1(output int rise);
        int n;
        rise = -1;
        n = 0;
        while (rise < 0 && n < 300) begin
            @(negedge clk);
            if (mv1) rise = cyc;
            n++;
        end
        if (rise < 0) bound_fail("dut1 output valid");
    endtask

    task automatic wait_valid4(output int rise);
        int n;
        rise = -1;
        n = 0;
        while (rise < 0 && n < 300) begin
            @(negedge clk);
            if (mv4) rise = cyc;
            n++;
        end
        if (rise < 0) bound_fail("dut4 output valid");
    endtask

    task automatic drain1();
        int n;
        n = 0;
        while (exp1.size() > 0 && n < 500) begin
            @(posedge clk);
            n++;
        end
        if (exp1.size() > 0) bound_fail("dut1 drain");
        #1;
    endtask

    task automatic drain4();
        int n;
        n = 0;
        while (exp4.size() > 0 && n < 500) begin
            @(posedge clk);
            n++;
        end
        if (exp4.size() > 0) bound_fail("dut4 drain");
        #1;
    endtask

    // ---------------- directed sequence, one lane per DUT ----------------
    task automatic run_dut1();
        int          hs, h2, rise, seen;
        logic [63:0] held;
        repeat (3) @(posedge clk);
        #1;
        check_bit("dut1 reset s_tready", sr1, 1'b0);
        check_bit("dut1 reset m_tvalid", mv1, 1'b0);
        check64("dut1 reset m_tdata", md1, 64'h0);
        rst1 = 1'b0;
        @(negedge clk);
        check_bit("dut1 s_tready before first edge", sr1, 1'b0);
        @(posedge clk); #1;
        check_bit("dut1 s_tready after first edge", sr1, 1'b1);

        send1(64'h0123_4567_89AB_CDEF, 48'h0, 1'b1, hs);
        wait_valid1(rise);
        check_int("dut1 latency", rise - hs, 32);
        drain1();

        send1(64'h0123_4567_89AB_CDEF, 48'hA5A5_5A5A_F00F, 1'b1, hs);
        drain1();

        send1(64'hDEAD_BEEF_0000_FFFF, 48'h1234_5678_9ABC, 1'b1, hs);
        send1(64'h8000_0000_0000_0001, 48'hFFFF_FFFF_FFFF, 1'b1, h2);
        check_int("dut1 block period", h2 - hs, 34);
        drain1();

        mr1 = 1'b0;
        send1(64'hFEDC_BA98_7654_3210, 48'h0F0F_F0F0_3C3C, 1'b1, hs);
        wait_valid1(rise);
        held = md1;
        repeat (10) begin
            @(negedge clk);
            check64("dut1 backpressure tdata", md1, held);
            check_int("dut1 backpressure tvalid/tready", int'({mv1, sr1}), 2);
        end
        @(posedge clk); #1;
        mr1 = 1'b1;
        repeat (5) @(posedge clk);
        #1;
        check_int("dut1 backpressure single transfer", exp1.size(), 0);
        check_bit("dut1 valid after release", mv1, 1'b0);

        send1(64'h1111_2222_3333_4444, 48'h5555_6666_7777, 1'b1, hs);
        repeat (5) @(posedge clk);
        #1;
        key1 = 48'hAAAA_9999_8888;
        drain1();

        send1(64'h0F1E_2D3C_4B5A_6978, 48'h0123_4567_89AB, 1'b0, hs);
        repeat (10) @(posedge clk);
        #1;
        rst1 = 1'b1;
        #1;
        check_bit("dut1 mid-run reset s_tready", sr1, 1'b0);
        check_bit("dut1 mid-run reset m_tvalid", mv1, 1'b0);
        check64("dut1 mid-run reset m_tdata", md1, 64'h0);
        repeat (2) @(posedge clk);
        #1;
        rst1 = 1'b0;
        seen = 0;
        repeat (40) begin
            @(negedge clk);
            if (mv1) seen++;
        end
        check_int("dut1 no stale output after reset", seen, 0);
        @(posedge clk); #1;
        send1(64'hCAFE_F00D_1234_ABCD, 48'h0123_4567_89AB, 1'b1, hs);
        drain1();
    endtask

    task automatic run_dut4();
        int          hs, prev, rise;
        logic [31:0] a, b, c, d;
        repeat (3) @(posedge clk);
        #1;
        check_bit("dut4 reset s_tready", sr4, 1'b0);
        check_bit("dut4 reset m_tvalid", mv4, 1'b0);
        rst4 = 1'b0;
        @(posedge clk); #1;

        send4(64'h0123_4567_89AB_CDEF, 48'hA5A5_5A5A_F00F, hs);
        wait_valid4(rise);
        check_int("dut4 latency", rise - hs, 8);
        drain4();

        send4(64'h0123_4567_89AB_CDEF, 48'h0, prev);
        for (int i = 0; i < 1000; i++) begin
            a = $urandom;
            b = $urandom;
            c = $urandom;
            d = $urandom;
            send4({a, b}, {c[15:0], d}, hs);
            check_int("dut4 block period", hs - prev, 10);
            prev = hs;
        end
        drain4();
    endtask

    initial begin
        n_checks = 0;
        n_errors = 0;
        rst1 = 1'b1;
        rst4 = 1'b1;
        key1 = '0;
        key4 = '0;
        sd1  = '0;
        sd4  = '0;
        sv1  = 1'b0;
        sv4  = 1'b0;
        mr1  = 1'b1;
        mr4  = 1'b1;
        fork
            run_dut1();
            run_dut4();
        join
        repeat (3) @(posedge clk);
        check_int("dut1 scoreboard empty", exp1.size(), 0);
        check_int("dut4 scoreboard empty", exp4.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire
